// File: rtl/sram_port_arbiter.sv
// Arbitrates one single-port synchronous SRAM between instruction-fetch and data ports.
// Optional performance counters are enabled with `define SRAM_ARB_PERF_CNT_EN.
module sram_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_gnt,
  output logic              inst_rvalid,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_gnt,
  output logic              data_rvalid,
  output logic [DATA_W-1:0] data_rdata,
  output logic              sram_en,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
`ifdef SRAM_ARB_PERF_CNT_EN
  ,
  output logic [31:0]       inst_stall_cnt,
  output logic [31:0]       data_stall_cnt,
  output logic [31:0]       starve_force_cnt
`endif
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_INST = 2'd1,
    OWN_DATA = 2'd2
  } owner_e;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  owner_e     pend_owner_reg, pend_owner_next;
  logic [3:0] wait_cnt_reg, wait_cnt_next;
  logic       starve_win;

  assign starve_win = inst_req & data_req & (wait_cnt_reg == MAX_WAIT_C);

  // Grants are held low while reset is asserted, independent of the requests.
  always_comb begin
    inst_gnt = 1'b0;
    data_gnt = 1'b0;
    if (resetn) begin
      if (inst_req && (!data_req || starve_win)) begin
        inst_gnt = 1'b1;
      end else if (data_req) begin
        data_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    sram_en    = inst_gnt | data_gnt;
    sram_we    = data_gnt & data_we;
    sram_addr  = '0;
    sram_wdata = '0;
    if (inst_gnt) begin
      sram_addr = inst_addr;
    end else if (data_gnt) begin
      sram_addr  = data_addr;
      sram_wdata = data_wdata;
    end
  end

  always_comb begin
    pend_owner_next = OWN_NONE;
    if (inst_gnt) begin
      pend_owner_next = OWN_INST;
    end else if (data_gnt && !data_we) begin
      pend_owner_next = OWN_DATA;
    end
  end

  always_comb begin
    wait_cnt_next = '0;
    if (inst_req && !inst_gnt) begin
      wait_cnt_next = (wait_cnt_reg == MAX_WAIT_C) ? wait_cnt_reg : wait_cnt_reg + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pend_owner_reg <= OWN_NONE;
      wait_cnt_reg   <= '0;
    end else begin
      pend_owner_reg <= pend_owner_next;
      wait_cnt_reg   <= wait_cnt_next;
    end
  end

  assign inst_rvalid = (pend_owner_reg == OWN_INST);
  assign data_rvalid = (pend_owner_reg == OWN_DATA);
  assign inst_rdata  = sram_rdata;
  assign data_rdata  = sram_rdata;

`ifdef SRAM_ARB_PERF_CNT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      inst_stall_cnt   <= '0;
      data_stall_cnt   <= '0;
      starve_force_cnt <= '0;
    end else begin
      if (inst_req && !inst_gnt) inst_stall_cnt <= inst_stall_cnt + 32'd1;
      if (data_req && !data_gnt) data_stall_cnt <= data_stall_cnt + 32'd1;
      if (starve_win && inst_gnt) starve_force_cnt <= starve_force_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: a behavioural SRAM, a reference memory and a
// return scoreboard. Define SRAM_ARB_PERF_CNT_EN to also check the performance counters.
module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_gnt;
  logic        inst_rvalid;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_we;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_gnt;
  logic        data_rvalid;
  logic [31:0] data_rdata;
  logic        sram_en;
  logic        sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
`ifdef SRAM_ARB_PERF_CNT_EN
  logic [31:0] inst_stall_cnt;
  logic [31:0] data_stall_cnt;
  logic [31:0] starve_force_cnt;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  owner;   // 0 none, 1 inst, 2 data
    logic [31:0] data;
  } ret_t;

  ret_t        sb_q[$];
  logic [31:0] mem     [0:63];
  logic [31:0] ref_mem [0:63];

  always #5 clk = ~clk;

  sram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .inst_req    (inst_req),
    .inst_addr   (inst_addr),
    .inst_gnt    (inst_gnt),
    .inst_rvalid (inst_rvalid),
    .inst_rdata  (inst_rdata),
    .data_req    (data_req),
    .data_we     (data_we),
    .data_addr   (data_addr),
    .data_wdata  (data_wdata),
    .data_gnt    (data_gnt),
    .data_rvalid (data_rvalid),
    .data_rdata  (data_rdata),
    .sram_en     (sram_en),
    .sram_we     (sram_we),
    .sram_addr   (sram_addr),
    .sram_wdata  (sram_wdata),
    .sram_rdata  (sram_rdata)
`ifdef SRAM_ARB_PERF_CNT_EN
    ,
    .inst_stall_cnt   (inst_stall_cnt),
    .data_stall_cnt   (data_stall_cnt),
    .starve_force_cnt (starve_force_cnt)
`endif
  );

  // Behavioural single-port SRAM with one-cycle read latency.
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we) mem[sram_addr[7:2]] <= sram_wdata;
      else         sram_rdata <= mem[sram_addr[7:2]];
    end
  end

  // One cycle: check the return owed from the previous grant, then this cycle's grant and SRAM drive.
  task automatic step(input logic exp_i, input logic exp_d, input string name);
    ret_t        exp_ret;
    ret_t        push_ret;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic        exp_we;
    @(negedge clk);
    exp_ret.owner = 2'd0;
    exp_ret.data  = '0;
    if (sb_q.size() > 0) exp_ret = sb_q.pop_front();
    checks++;
    if (inst_rvalid !== (exp_ret.owner == 2'd1) || data_rvalid !== (exp_ret.owner == 2'd2)) begin
      errors++;
      $display("FAIL %s rvalid: got inst=%b data=%b, expected owner %0d", name, inst_rvalid, data_rvalid, exp_ret.owner);
    end
    if (exp_ret.owner == 2'd1) begin
      checks++;
      if (inst_rdata !== exp_ret.data) begin
        errors++;
        $display("FAIL %s inst_rdata: got %h, expected %h", name, inst_rdata, exp_ret.data);
      end
    end
    if (exp_ret.owner == 2'd2) begin
      checks++;
      if (data_rdata !== exp_ret.data) begin
        errors++;
        $display("FAIL %s data_rdata: got %h, expected %h", name, data_rdata, exp_ret.data);
      end
    end
    checks++;
    if (inst_gnt !== exp_i || data_gnt !== exp_d) begin
      errors++;
      $display("FAIL %s grant: got inst=%b data=%b, expected inst=%b data=%b", name, inst_gnt, data_gnt, exp_i, exp_d);
    end
    exp_we    = exp_d & data_we;
    exp_addr  = exp_i ? inst_addr : (exp_d ? data_addr : 32'h0);
    exp_wdata = exp_d ? data_wdata : 32'h0;
    checks++;
    if (sram_en !== (exp_i | exp_d) || sram_we !== exp_we || sram_addr !== exp_addr || sram_wdata !== exp_wdata) begin
      errors++;
      $display("FAIL %s sram drive: got en=%b we=%b addr=%h wdata=%h, expected en=%b we=%b addr=%h wdata=%h",
               name, sram_en, sram_we, sram_addr, sram_wdata, exp_i | exp_d, exp_we, exp_addr, exp_wdata);
    end
    $display("%-12s ireq=%b dreq=%b we=%b | gnt i=%b d=%b | rvalid i=%b d=%b rdata=%h",
             name, inst_req, data_req, data_we, inst_gnt, data_gnt, inst_rvalid, data_rvalid, sram_rdata);
    push_ret.owner = 2'd0;
    push_ret.data  = '0;
    if (exp_i) begin
      push_ret.owner = 2'd1;
      push_ret.data  = ref_mem[inst_addr[7:2]];
    end else if (exp_d && !data_we) begin
      push_ret.owner = 2'd2;
      push_ret.data  = ref_mem[data_addr[7:2]];
    end
    if (exp_d && data_we) ref_mem[data_addr[7:2]] = data_wdata;
    sb_q.push_back(push_ret);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    inst_req = 1'b0; data_req = 1'b0; data_we = 1'b0;
    inst_addr = '0; data_addr = '0; data_wdata = '0;
  endtask

  task automatic test_reset();
    inst_req = 1'b1; data_req = 1'b1; data_we = 1'b1;
    inst_addr = 32'h1c000000; data_addr = 32'h40; data_wdata = 32'h12345678;
    resetn = 1'b0;
    #2;
    checks++;
    if (inst_gnt !== 1'b0 || data_gnt !== 1'b0 || inst_rvalid !== 1'b0 || data_rvalid !== 1'b0 ||
        sram_en !== 1'b0 || sram_we !== 1'b0) begin
      errors++;
      $display("FAIL reset outputs: got gnt=%b%b rvalid=%b%b en=%b we=%b, expected all 0",
               inst_gnt, data_gnt, inst_rvalid, data_rvalid, sram_en, sram_we);
    end
    repeat (2) @(posedge clk);
    #1;
    idle_inputs();
    resetn = 1'b1;
    sb_q.delete();
    step(1'b0, 1'b0, "reset_idle");
  endtask

  task automatic test_inst_only();
    inst_req = 1'b1; inst_addr = 32'h1c000000;
    repeat (3) step(1'b1, 1'b0, "inst_only");
    inst_req = 1'b0;
    step(1'b0, 1'b0, "inst_drain");
  endtask

  task automatic test_conflict();
    inst_req = 1'b1; inst_addr = 32'h1c000004;
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'h100;
    step(1'b0, 1'b1, "conflict");
    data_req = 1'b0;
    step(1'b1, 1'b0, "conflict_i");
    inst_req = 1'b0;
    step(1'b0, 1'b0, "conflict_dr");
  endtask

  task automatic test_starvation();
`ifdef SRAM_ARB_PERF_CNT_EN
    logic [31:0] base_i, base_d, base_f;
    base_i = inst_stall_cnt; base_d = data_stall_cnt; base_f = starve_force_cnt;
`endif
    inst_req = 1'b1; inst_addr = 32'h1c000008;
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'h80;
    repeat (4) step(1'b0, 1'b1, "starve_d");
    step(1'b1, 1'b0, "starve_force");
    inst_req = 1'b0;
    step(1'b0, 1'b1, "starve_after");
    data_req = 1'b0;
    step(1'b0, 1'b0, "starve_drain");
`ifdef SRAM_ARB_PERF_CNT_EN
    checks++;
    if (inst_stall_cnt - base_i !== 32'd4 || data_stall_cnt - base_d !== 32'd1 || starve_force_cnt - base_f !== 32'd1) begin
      errors++;
      $display("FAIL perf counters: got inst_stall=%0d data_stall=%0d force=%0d, expected 4 1 1",
               inst_stall_cnt - base_i, data_stall_cnt - base_d, starve_force_cnt - base_f);
    end
`endif
  endtask

  task automatic test_write_read();
    data_req = 1'b1; data_we = 1'b1; data_addr = 32'h40; data_wdata = 32'hdeadbeef;
    step(1'b0, 1'b1, "write");
    data_we = 1'b0; data_wdata = 32'h0;
    step(1'b0, 1'b1, "read_back");
    data_req = 1'b0;
    step(1'b0, 1'b0, "read_drain");
  endtask

  task automatic test_back_to_back();
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'h0c;
    step(1'b0, 1'b1, "b2b_d0");
    data_req = 1'b0; inst_req = 1'b1; inst_addr = 32'h1c000010;
    step(1'b1, 1'b0, "b2b_i1");
    inst_req = 1'b0; data_req = 1'b1; data_addr = 32'h40;
    step(1'b0, 1'b1, "b2b_d2");
    data_req = 1'b0;
    step(1'b0, 1'b0, "b2b_drain");
  endtask

  task automatic test_mid_read_reset();
    inst_req = 1'b1; inst_addr = 32'h1c000014;
    step(1'b1, 1'b0, "pre_reset");
    resetn = 1'b0;
    #1;
    checks++;
    if (inst_rvalid !== 1'b0 || inst_gnt !== 1'b0 || sram_en !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got inst_rvalid=%b inst_gnt=%b sram_en=%b, expected 0 0 0", inst_rvalid, inst_gnt, sram_en);
    end
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    step(1'b1, 1'b0, "post_reset");
    inst_req = 1'b0;
    step(1'b0, 1'b0, "post_drain");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i]     = 32'ha5000000 | (i * 32'h00010101);
      ref_mem[i] = 32'ha5000000 | (i * 32'h00010101);
    end
    mem[0]     = 32'h02800421;
    ref_mem[0] = 32'h02800421;
    test_reset();
    test_inst_only();
    test_conflict();
    test_starvation();
    test_write_read();
    test_back_to_back();
    test_mid_read_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
